ahb_mem_slave: RTL and testbench

- AHB slave memory responder; the far end of the rotation DMA master's AHB interface.
- Serves the DMA's source-image reads and destination-image writes from an internal word-addressed RAM, with a programmable number of wait states.
- Used as the system-level bench memory and as an on-chip frame scratch buffer.
- Single clock domain on I_HCLK.

---
 rtl/ahb_mem_slave.sv | 168 ++++++++++++++++
 tb/tb_ahb_mem_slave.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mem_slave.sv
// ahb_mem_slave: AHB slave memory responder backed by a word-addressed RAM of
// 2^ADDR_W 32-bit words, with WAIT_CYCLES wait states per data phase.
// Optional feature macro AHB_MEM_ALIGN_CHECK_EN: when defined, unaligned
// transfers and HSIZE > word receive the two-cycle ERROR response; when
// undefined, low address bits are ignored and oversize transfers act as words.

module ahb_mem_slave #(
   parameter int unsigned ADDR_W      = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        I_HCLK,
   input  logic        I_HRESET,
   input  logic        I_HSEL,
   input  logic [31:0] I_HADDR,
   input  logic [1:0]  I_HTRANS,
   input  logic        I_HWRITE,
   input  logic [2:0]  I_HSIZE,
   input  logic [2:0]  I_HBURST,
   input  logic [31:0] I_HWDATA,
   input  logic        I_HREADY,
   output logic [31:0] O_HRDATA,
   output logic        O_HREADYOUT,
   output logic [1:0]  O_HRESP
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } state_t;

   localparam int unsigned DEPTH     = 1 << ADDR_W;
   localparam logic [32:0] WINDOW    = 33'(DEPTH) << 2;
   localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   logic [31:0]       mem_q [DEPTH];
   state_t            state_q, state_d;
   logic [3:0]        wcnt_q, wcnt_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              write_q, write_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       rdata_q, rdata_d;

   logic              accept;
   logic [31:0]       offset;
   logic              in_range;
   logic              addr_err;
   logic [3:0]        be_new;
   logic [ADDR_W-1:0] idx_new;
   logic              wr_en;
   logic [31:0]       wr_word;
   logic [31:0]       rd_word;
   logic              unused_bits;

   // Burst type and the BUSY/IDLE distinction carry no meaning for this slave.
   assign unused_bits = ^{I_HBURST, I_HTRANS[0]};

   // Address-phase decode: window check, word index and byte-lane enables.
   always_comb begin
      offset   = I_HADDR - BASE_ADDR;
      in_range = {1'b0, offset} < WINDOW;
      idx_new  = offset[ADDR_W+1:2];
      accept   = I_HSEL & I_HREADY & I_HTRANS[1];
      addr_err = ~in_range;
      be_new   = 4'b1111;
`ifdef AHB_MEM_ALIGN_CHECK_EN
      case (I_HSIZE)
         3'b000: be_new = 4'b0001 << I_HADDR[1:0];
         3'b001: begin
            be_new = I_HADDR[1] ? 4'b1100 : 4'b0011;
            if (I_HADDR[0]) addr_err = 1'b1;
         end
         3'b010: if (I_HADDR[1:0] != 2'b00) addr_err = 1'b1;
         default: addr_err = 1'b1;
      endcase
`else
      case (I_HSIZE)
         3'b000:  be_new = 4'b0001 << I_HADDR[1:0];
         3'b001:  be_new = I_HADDR[1] ? 4'b1100 : 4'b0011;
         default: be_new = 4'b1111;
      endcase
`endif
   end

   // Write merge for the committing data phase, and read forwarding so a read
   // accepted alongside a write to the same word sees the merged result.
   always_comb begin
      wr_en   = (state_q == ST_DATA) & write_q & ~I_HRESET;
      wr_word = mem_q[idx_q];
      for (int unsigned i = 0; i < 4; i++) begin
         if (be_q[i]) wr_word[8*i +: 8] = I_HWDATA[8*i +: 8];
      end
      rd_word = mem_q[idx_new];
      if (wr_en && (idx_new == idx_q)) rd_word = wr_word;
   end

   // Next-state logic: address-phase capture, wait counting, error sequencing.
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      idx_d   = idx_q;
      write_d = write_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE, ST_DATA, ST_ERR2: begin
            if (accept) begin
               idx_d   = idx_new;
               write_d = I_HWRITE;
               be_d    = be_new;
               if (addr_err) begin
                  state_d = ST_ERR1;
               end else if (WAIT_CYCLES != 0) begin
                  state_d = ST_WAIT;
                  wcnt_d  = WAIT_LOAD;
               end else begin
                  state_d = ST_DATA;
                  rdata_d = rd_word;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (wcnt_q == 4'd0) begin
               state_d = ST_DATA;
               rdata_d = mem_q[idx_q];
            end else begin
               wcnt_d = wcnt_q - 4'd1;
            end
         end
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and read-data registers with synchronous reset.
   always_ff @(posedge I_HCLK) begin
      if (I_HRESET) begin
         state_q <= ST_IDLE;
         wcnt_q  <= '0;
         idx_q   <= '0;
         write_q <= 1'b0;
         be_q    <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         idx_q   <= idx_d;
         write_q <= write_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
      end
   end

   // RAM write port; contents survive reset.
   always_ff @(posedge I_HCLK) begin
      if (wr_en) mem_q[idx_q] <= wr_word;
   end

   assign O_HRDATA    = rdata_q;
   assign O_HREADYOUT = ~((state_q == ST_WAIT) || (state_q == ST_ERR1));
   assign O_HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? 2'b01 : 2'b00;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// tb_ahb_mem_slave: two slave instances (zero and three wait states, distinct
// bases) driven by a pipelined AHB master task; results are compared against
// a byte-level memory model built from the transfer rules.

module tb_ahb_mem_slave;

   localparam int          AW    = 8;
   localparam int          WORDS = 256;
   localparam logic [31:0] BASE0 = 32'h0000_1000;
   localparam logic [31:0] BASE1 = 32'h2000_0000;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  size;
      logic [1:0]  trans;
      logic [31:0] wdata;
   } tx_t;

   logic        clk = 1'b0;
   logic        hreset = 1'b1;
   logic [1:0]  hsel = 2'b00;
   logic [31:0] haddr = '0;
   logic [1:0]  htrans = 2'b00;
   logic        hwrite = 1'b0;
   logic [2:0]  hsize = 3'b010;
   logic [2:0]  hburst = 3'b000;
   logic [31:0] hwdata = '0;
   logic [31:0] rdata0, rdata1;
   logic        rdy0, rdy1;
   logic [1:0]  resp0, resp1;

   int n_checks = 0;
   int n_pass = 0;

   tx_t         txq[$];
   int          obs_wait[$];
   logic [1:0]  obs_resp[$];
   logic [1:0]  obs_wresp[$];
   logic [31:0] obs_rdata[$];
   logic [31:0] mdl [2][WORDS];

   always #5 clk = ~clk;

   ahb_mem_slave #(.ADDR_W(AW), .BASE_ADDR(BASE0), .WAIT_CYCLES(0)) u_dut0 (
      .I_HCLK(clk), .I_HRESET(hreset), .I_HSEL(hsel[0]), .I_HADDR(haddr),
      .I_HTRANS(htrans), .I_HWRITE(hwrite), .I_HSIZE(hsize), .I_HBURST(hburst),
      .I_HWDATA(hwdata), .I_HREADY(rdy0), .O_HRDATA(rdata0),
      .O_HREADYOUT(rdy0), .O_HRESP(resp0));

   ahb_mem_slave #(.ADDR_W(AW), .BASE_ADDR(BASE1), .WAIT_CYCLES(3)) u_dut1 (
      .I_HCLK(clk), .I_HRESET(hreset), .I_HSEL(hsel[1]), .I_HADDR(haddr),
      .I_HTRANS(htrans), .I_HWRITE(hwrite), .I_HSIZE(hsize), .I_HBURST(hburst),
      .I_HWDATA(hwdata), .I_HREADY(rdy1), .O_HRDATA(rdata1),
      .O_HREADYOUT(rdy1), .O_HRESP(resp1));

   // Reference model: applies one completed transfer and returns what the bus
   // should have shown for it (wait cycles, final response, read data).
   task automatic model_step(input int d, input tx_t t, output int ew,
                             output logic [1:0] er, output logic [31:0] ed,
                             output bit erd);
      logic [31:0] off;
      int nb, first, idx;
      bit err;
      off = t.addr - (d ? BASE1 : BASE0);
      nb  = (t.size == 3'd0) ? 1 : (t.size == 3'd1) ? 2 : 4;
      err = (off >= 32'(4 * WORDS));
`ifdef AHB_MEM_ALIGN_CHECK_EN
      if (t.size > 3'd2 || (t.addr % nb) != 0) err = 1'b1;
`endif
      erd = 1'b0;
      ed  = '0;
      if (!t.trans[1]) begin
         ew = 0; er = 2'b00;
      end else if (err) begin
         ew = 1; er = 2'b01;
      end else begin
         ew  = d ? 3 : 0;
         er  = 2'b00;
         idx = int'(off / 4);
         if (t.wr) begin
            first = int'(off % 4) / nb * nb;
            for (int b = first; b < first + nb; b++)
               mdl[d][idx][8*b +: 8] = t.wdata[8*b +: 8];
         end else begin
            erd = 1'b1;
            ed  = mdl[d][idx];
         end
      end
   endtask

   // Pipelined master: plays txq to instance d and records per-transfer
   // observations in completion order.
   task automatic run_seq(input int d);
      int a = 0, p = -1, waits = 0, cyc = 0, limit;
      logic r;
      logic [1:0] rs, last_wr;
      logic [31:0] rd;
      limit = 8 * txq.size() + 20;
      last_wr = 2'b00;
      obs_wait.delete(); obs_resp.delete(); obs_wresp.delete(); obs_rdata.delete();
      while ((a < txq.size() || p >= 0) && cyc < limit) begin
         @(negedge clk);
         cyc++;
         if (p >= 0) hwdata = txq[p].wdata;
         r  = d ? rdy1 : rdy0;
         rs = d ? resp1 : resp0;
         rd = d ? rdata1 : rdata0;
         if (!r) begin
            waits++;
            last_wr = rs;
         end else begin
            if (p >= 0) begin
               obs_wait.push_back(waits);
               obs_resp.push_back(rs);
               obs_wresp.push_back(last_wr);
               obs_rdata.push_back(rd);
            end
            waits = 0; last_wr = 2'b00; p = -1;
            if (a < txq.size()) begin
               haddr  = txq[a].addr;
               htrans = txq[a].trans;
               hwrite = txq[a].wr;
               hsize  = txq[a].size;
               hsel   = d ? 2'b10 : 2'b01;
               p = a;
               a++;
            end else begin
               htrans = 2'b00;
               hsel   = 2'b00;
            end
         end
      end
      if (a < txq.size() || p >= 0) begin
         n_checks++;
         $display("FAIL timeout dut%0d: done %0d of %0d transfers in %0d cycles",
                  d, a, txq.size(), cyc);
      end
      htrans = 2'b00;
      hsel   = 2'b00;
   endtask

   function automatic tx_t mk(input logic [31:0] addr, input logic wr,
                              input logic [2:0] size, input logic [1:0] trans,
                              input logic [31:0] wdata);
      tx_t t;
      t.addr = addr; t.wr = wr; t.size = size; t.trans = trans; t.wdata = wdata;
      return t;
   endfunction

   function automatic tx_t rand_tx(input logic [31:0] base);
      int unsigned r, ra;
      logic [31:0] addr;
      logic [2:0] size;
      logic [1:0] trans;
      r  = $urandom_range(0, 19);
      trans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
      ra = $urandom_range(0, 9);
      if (ra == 0)      addr = base + 32'(4 * WORDS) + $urandom_range(0, 255);
      else if (ra == 1) addr = base - 32'd1 - $urandom_range(0, 15);
      else if (ra < 6)  addr = base + $urandom_range(0, 31);
      else              addr = base + $urandom_range(0, 4 * WORDS - 1);
      size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      return mk(addr, 1'($urandom_range(0, 1)), size, trans, $urandom);
   endfunction

   task automatic test_reset();
      hreset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({rdy0, resp0, rdata0} !== {1'b1, 2'b00, 32'h0})
         $display("FAIL reset_dut0 got rdy=%b resp=%b rdata=%h exp 1/00/0", rdy0, resp0, rdata0);
      else n_pass++;
      n_checks++;
      if ({rdy1, resp1, rdata1} !== {1'b1, 2'b00, 32'h0})
         $display("FAIL reset_dut1 got rdy=%b resp=%b rdata=%h exp 1/00/0", rdy1, resp1, rdata1);
      else n_pass++;
      hreset = 1'b0;
   endtask

   task automatic test_preload();
      int ew; logic [1:0] er; logic [31:0] ed; bit erd;
      for (int d = 0; d < 2; d++) begin
         txq.delete();
         for (int i = 0; i < WORDS; i++)
            txq.push_back(mk((d ? BASE1 : BASE0) + 32'(4 * i), 1'b1, 3'b010, 2'b10, $urandom));
         run_seq(d);
         for (int i = 0; i < txq.size(); i++) begin
            model_step(d, txq[i], ew, er, ed, erd);
            n_checks++;
            if (obs_wait[i] !== ew || obs_resp[i] !== er)
               $display("FAIL preload%0d[%0d] waits=%0d resp=%b exp waits=%0d resp=%b",
                        d, i, obs_wait[i], obs_resp[i], ew, er);
            else n_pass++;
         end
      end
   endtask

   task automatic test_basic_rw();
      int ew; logic [1:0] er; logic [31:0] ed; bit erd;
      txq.delete();
      txq.push_back(mk(BASE0 + 32'h10, 1'b1, 3'b010, 2'b10, 32'hDEAD_BEEF));
      txq.push_back(mk(BASE0 + 32'h10, 1'b0, 3'b010, 2'b10, 32'h0));
      run_seq(0);
      for (int i = 0; i < txq.size(); i++) begin
         model_step(0, txq[i], ew, er, ed, erd);
         n_checks++;
         if (obs_wait[i] !== ew || obs_resp[i] !== er)
            $display("FAIL basic_ctl[%0d] waits=%0d resp=%b exp waits=%0d resp=%b",
                     i, obs_wait[i], obs_resp[i], ew, er);
         else n_pass++;
      end
      n_checks++;
      if (obs_rdata[1] !== 32'hDEAD_BEEF)
         $display("FAIL basic_rdata got %h exp deadbeef", obs_rdata[1]);
      else n_pass++;
   endtask

   task automatic test_wait_burst();
      int ew; logic [1:0] er; logic [31:0] ed; bit erd;
      txq.delete();
      for (int i = 0; i < 4; i++)
         txq.push_back(mk(BASE1 + 32'(4 * i), 1'b0, 3'b010, (i == 0) ? 2'b10 : 2'b11, 32'h0));
      hburst = 3'b011;
      run_seq(1);
      hburst = 3'b000;
      for (int i = 0; i < txq.size(); i++) begin
         model_step(1, txq[i], ew, er, ed, erd);
         n_checks++;
         if (obs_wait[i] !== ew || obs_resp[i] !== er || (ew > 0 && obs_wresp[i] !== er))
            $display("FAIL burst_ctl[%0d] waits=%0d resp=%b wresp=%b exp waits=%0d resp=%b",
                     i, obs_wait[i], obs_resp[i], obs_wresp[i], ew, er);
         else n_pass++;
         n_checks++;
         if (obs_rdata[i] !== ed)
            $display("FAIL burst_rdata[%0d] got %h exp %h", i, obs_rdata[i], ed);
         else n_pass++;
      end
   endtask

   task automatic test_byte_lanes();
      int ew; logic [1:0] er; logic [31:0] ed; bit erd;
      txq.delete();
      txq.push_back(mk(BASE0 + 32'h20, 1'b1, 3'b010, 2'b10, 32'h1122_3344));
      txq.push_back(mk(BASE0 + 32'h21, 1'b1, 3'b000, 2'b10, 32'h0000_AA00));
      txq.push_back(mk(BASE0 + 32'h20, 1'b0, 3'b010, 2'b10, 32'h0));
      txq.push_back(mk(BASE0 + 32'h22, 1'b1, 3'b001, 2'b10, 32'h5566_0000));
      txq.push_back(mk(BASE0 + 32'h20, 1'b0, 3'b010, 2'b10, 32'h0));
      run_seq(0);
      for (int i = 0; i < txq.size(); i++) begin
         model_step(0, txq[i], ew, er, ed, erd);
         n_checks++;
         if (obs_wait[i] !== ew || obs_resp[i] !== er || (erd && obs_rdata[i] !== ed))
            $display("FAIL lanes[%0d] waits=%0d resp=%b rdata=%h exp waits=%0d resp=%b rdata=%h",
                     i, obs_wait[i], obs_resp[i], obs_rdata[i], ew, er, ed);
         else n_pass++;
      end
      n_checks++;
      if (obs_rdata[2] !== 32'h1122_AA44)
         $display("FAIL lanes_byte got %h exp 1122aa44", obs_rdata[2]);
      else n_pass++;
      n_checks++;
      if (obs_rdata[4] !== 32'h5566_AA44)
         $display("FAIL lanes_half got %h exp 5566aa44", obs_rdata[4]);
      else n_pass++;
   endtask

   task automatic test_out_of_range();
      int ew; logic [1:0] er; logic [31:0] ed; bit erd;
      for (int d = 0; d < 2; d++) begin
         txq.delete();
         txq.push_back(mk((d ? BASE1 : BASE0) + 32'(4 * WORDS), 1'b1, 3'b010, 2'b10, 32'h0BAD_F00D));
         txq.push_back(mk((d ? BASE1 : BASE0), 1'b0, 3'b010, 2'b10, 32'h0));
         txq.push_back(mk((d ? BASE1 : BASE0) - 32'd4, 1'b1, 3'b010, 2'b10, 32'h0BAD_F00D));
         txq.push_back(mk((d ? BASE1 : BASE0) + 32'(4 * WORDS - 4), 1'b0, 3'b010, 2'b10, 32'h0));
         run_seq(d);
         for (int i = 0; i < txq.size(); i++) begin
            model_step(d, txq[i], ew, er, ed, erd);
            n_checks++;
            if (obs_wait[i] !== ew || obs_resp[i] !== er || (ew > 0 && obs_wresp[i] !== er)
                || (erd && obs_rdata[i] !== ed))
               $display("FAIL range%0d[%0d] waits=%0d resp=%b wresp=%b rdata=%h exp waits=%0d resp=%b rdata=%h",
                        d, i, obs_wait[i], obs_resp[i], obs_wresp[i], obs_rdata[i], ew, er, ed);
            else n_pass++;
         end
         n_checks++;
         if (obs_wait[0] !== 1 || obs_resp[0] !== 2'b01 || obs_wresp[0] !== 2'b01)
            $display("FAIL range_err%0d waits=%0d resp=%b wresp=%b exp 1/01/01",
                     d, obs_wait[0], obs_resp[0], obs_wresp[0]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      int ew; logic [1:0] er; logic [31:0] ed; bit erd;
      for (int d = 0; d < 2; d++) begin
         txq.delete();
         txq.push_back(mk((d ? BASE1 : BASE0) + 32'h40, 1'b1, 3'b010, 2'b10, $urandom));
         txq.push_back(mk((d ? BASE1 : BASE0) + 32'h40, 1'b0, 3'b010, 2'b10, 32'h0));
         txq.push_back(mk((d ? BASE1 : BASE0) + 32'h41, 1'b1, 3'b000, 2'b11, $urandom));
         txq.push_back(mk((d ? BASE1 : BASE0) + 32'h40, 1'b0, 3'b010, 2'b11, 32'h0));
         for (int i = 0; i < 60; i++) txq.push_back(rand_tx(d ? BASE1 : BASE0));
         run_seq(d);
         for (int i = 0; i < txq.size(); i++) begin
            model_step(d, txq[i], ew, er, ed, erd);
            n_checks++;
            if (obs_wait[i] !== ew || obs_resp[i] !== er || (ew > 0 && obs_wresp[i] !== er)
                || (erd && obs_rdata[i] !== ed))
               $display("FAIL b2b%0d[%0d] a=%h s=%0d w=%b waits=%0d resp=%b rdata=%h exp waits=%0d resp=%b rdata=%h",
                        d, i, txq[i].addr, txq[i].size, txq[i].wr, obs_wait[i], obs_resp[i],
                        obs_rdata[i], ew, er, ed);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_in_wait();
      int ew; logic [1:0] er; logic [31:0] ed; bit erd;
      @(negedge clk);
      haddr = BASE1 + 32'h40; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010; hsel = 2'b10;
      @(negedge clk);
      htrans = 2'b00; hsel = 2'b00; hwdata = 32'hBAD0_BAD0;
      n_checks++;
      if (rdy1 !== 1'b0) $display("FAIL rstwait_inwait got rdy=%b exp 0", rdy1);
      else n_pass++;
      hreset = 1'b1;
      @(negedge clk);
      hreset = 1'b0;
      n_checks++;
      if ({rdy1, resp1, rdata1} !== {1'b1, 2'b00, 32'h0})
         $display("FAIL rstwait_after got rdy=%b resp=%b rdata=%h exp 1/00/0", rdy1, resp1, rdata1);
      else n_pass++;
      txq.delete();
      txq.push_back(mk(BASE1 + 32'h40, 1'b0, 3'b010, 2'b10, 32'h0));
      run_seq(1);
      model_step(1, txq[0], ew, er, ed, erd);
      n_checks++;
      if (obs_resp[0] !== er || obs_rdata[0] !== ed)
         $display("FAIL rstwait_lost resp=%b rdata=%h exp resp=%b rdata=%h",
                  obs_resp[0], obs_rdata[0], er, ed);
      else n_pass++;
   endtask

   task automatic test_align();
      int ew; logic [1:0] er; logic [31:0] ed; bit erd;
      logic [31:0] exp_word;
      txq.delete();
      txq.push_back(mk(BASE0, 1'b1, 3'b010, 2'b10, 32'h1111_1111));
      txq.push_back(mk(BASE0 + 32'h2, 1'b1, 3'b010, 2'b10, 32'hCAFE_F00D));
      txq.push_back(mk(BASE0, 1'b0, 3'b010, 2'b10, 32'h0));
      run_seq(0);
      for (int i = 0; i < txq.size(); i++) begin
         model_step(0, txq[i], ew, er, ed, erd);
         n_checks++;
         if (obs_wait[i] !== ew || obs_resp[i] !== er || (erd && obs_rdata[i] !== ed))
            $display("FAIL align[%0d] waits=%0d resp=%b rdata=%h exp waits=%0d resp=%b rdata=%h",
                     i, obs_wait[i], obs_resp[i], obs_rdata[i], ew, er, ed);
         else n_pass++;
      end
`ifdef AHB_MEM_ALIGN_CHECK_EN
      exp_word = 32'h1111_1111;
`else
      exp_word = 32'hCAFE_F00D;
`endif
      n_checks++;
      if (obs_rdata[2] !== exp_word)
         $display("FAIL align_word got %h exp %h", obs_rdata[2], exp_word);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_preload();
      test_basic_rw();
      test_wait_burst();
      test_byte_lanes();
      test_out_of_range();
      test_back_to_back();
      test_reset_in_wait();
      test_align();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
